// File: rtl/user_mgr_arbiter.sv
// user_mgr_arbiter
//   Round-robin arbiter that shares one OBI manager port between NumReq
//   requesters. It keeps an in-order FIFO of granted port indices, up to
//   MaxTrans deep, so that each response is routed back to the requester
//   that issued it.
//
//   Optional feature macro: USER_MGR_ARB_PROTO_CHECK_EN
//     defined   -> proto_err_o is sticky until reset. It sets on a response
//                  that arrives with no transaction outstanding, or when the
//                  locked requester drops req_i before it is granted.
//     undefined -> proto_err_o is tied to 0. Orphan responses are still dropped.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   req_i/addr_i/we_i/be_i/wdata_i   per-port request channels (port k at slice k)
//   gnt_o, rvalid_o          per-port grant / response valid (one-hot or zero)
//   rdata_o, err_o           shared response data / error
//   mgr_*_o, mgr_gnt_i       manager-side request channel
//   mgr_rvalid_i/rdata_i/err_i   manager-side response channel
//   proto_err_o              sticky protocol-error flag
module user_mgr_arbiter #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MaxTrans  = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumReq-1:0]               req_i,
  input  logic [NumReq*AddrWidth-1:0]     addr_i,
  input  logic [NumReq-1:0]               we_i,
  input  logic [NumReq*(DataWidth/8)-1:0] be_i,
  input  logic [NumReq*DataWidth-1:0]     wdata_i,
  output logic [NumReq-1:0]               gnt_o,
  output logic [NumReq-1:0]               rvalid_o,
  output logic [DataWidth-1:0]            rdata_o,
  output logic                            err_o,
  output logic                            mgr_req_o,
  output logic [AddrWidth-1:0]            mgr_addr_o,
  output logic                            mgr_we_o,
  output logic [DataWidth/8-1:0]          mgr_be_o,
  output logic [DataWidth-1:0]            mgr_wdata_o,
  input  logic                            mgr_gnt_i,
  input  logic                            mgr_rvalid_i,
  input  logic [DataWidth-1:0]            mgr_rdata_i,
  input  logic                            mgr_err_i,
  output logic                            proto_err_o
);
  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned BeW  = DataWidth / 8;
  localparam int unsigned CntW = $clog2(MaxTrans + 1);
  localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;

  // Packed per-port views of the flattened input buses
  logic [NumReq-1:0][AddrWidth-1:0] addr_v;
  logic [NumReq-1:0][BeW-1:0]       be_v;
  logic [NumReq-1:0][DataWidth-1:0] wdata_v;
  assign addr_v  = addr_i;
  assign be_v    = be_i;
  assign wdata_v = wdata_i;

  logic [IdxW-1:0]               prio_q, prio_d, sel_q, sel_d;
  logic                          lock_q, lock_d;
  logic [CntW-1:0]               cnt_q, cnt_d;
  logic [PtrW-1:0]               wr_q, wr_d, rd_q, rd_d;
  logic [MaxTrans-1:0][IdxW-1:0] fifo_q;

  logic [IdxW-1:0] rr_sel, sel, head;
  logic            rr_hit, mgr_req, push, pop, rsp;
  int              k;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxTrans - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // First requesting port at or above prio, wrapping around
  always_comb begin
    rr_sel = prio_q;
    rr_hit = 1'b0;
    k      = 0;
    for (int i = 0; i < int'(NumReq); i++) begin
      k = int'(prio_q) + i;
      if (k >= int'(NumReq)) k = k - int'(NumReq);
      if (!rr_hit && req_i[IdxW'(k)]) begin
        rr_hit = 1'b1;
        rr_sel = IdxW'(k);
      end
    end
  end

  // The full check uses the registered count, so a pop in the same cycle
  // does not reopen the request path until the next cycle.
  assign sel     = lock_q ? sel_q : rr_sel;
  assign mgr_req = !rst_i && (lock_q || (|req_i)) && (cnt_q < CntW'(MaxTrans));
  assign push    = mgr_req && mgr_gnt_i;
  assign rsp     = !rst_i && mgr_rvalid_i;
  assign pop     = rsp && (cnt_q != '0);
  assign head    = fifo_q[rd_q];

  assign mgr_req_o   = mgr_req;
  assign mgr_addr_o  = mgr_req ? addr_v[sel]  : '0;
  assign mgr_we_o    = mgr_req ? we_i[sel]    : 1'b0;
  assign mgr_be_o    = mgr_req ? be_v[sel]    : '0;
  assign mgr_wdata_o = mgr_req ? wdata_v[sel] : '0;

  assign gnt_o    = push ? (NumReq'(1) << sel)  : '0;
  assign rvalid_o = pop  ? (NumReq'(1) << head) : '0;
  assign rdata_o  = rsp  ? mgr_rdata_i : '0;
  assign err_o    = rsp  ? mgr_err_i   : 1'b0;

  always_comb begin
    prio_d = prio_q;
    lock_d = lock_q;
    sel_d  = sel_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q + CntW'(push) - CntW'(pop);
    if (push) begin
      lock_d = 1'b0;
      prio_d = (sel == IdxW'(NumReq - 1)) ? '0 : sel + IdxW'(1);
      wr_d   = ptr_inc(wr_q);
    end else if (mgr_req) begin
      // Hold the offered request stable until the manager accepts it
      lock_d = 1'b1;
      sel_d  = sel;
    end
    if (pop) rd_d = ptr_inc(rd_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= '0;
      lock_q <= 1'b0;
      sel_q  <= '0;
      cnt_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      fifo_q <= '0;
    end else begin
      prio_q <= prio_d;
      lock_q <= lock_d;
      sel_q  <= sel_d;
      cnt_q  <= cnt_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      if (push) fifo_q[wr_q] <= sel;
    end
  end

`ifdef USER_MGR_ARB_PROTO_CHECK_EN
  logic perr_q, perr_d;
  assign perr_d = perr_q
                | (mgr_rvalid_i && (cnt_q == '0))
                | (lock_q && !req_i[sel_q]);
  always_ff @(posedge clk_i) begin
    if (rst_i) perr_q <= 1'b0;
    else       perr_q <= perr_d;
  end
  assign proto_err_o = perr_q;
`else
  assign proto_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_user_mgr_arbiter.sv
module tb_user_mgr_arbiter;
  logic        clk = 1'b0;
  logic        rst_i;
  logic [1:0]  req_i, we_i, gnt_o, rvalid_o;
  logic [63:0] addr_i, wdata_i;
  logic [7:0]  be_i;
  logic [31:0] rdata_o, mgr_addr_o, mgr_wdata_o, mgr_rdata_i;
  logic        err_o, mgr_req_o, mgr_we_o, mgr_gnt_i, mgr_rvalid_i, mgr_err_i, proto_err_o;
  logic [3:0]  mgr_be_o;

  int checks   = 0;
  int failures = 0;
  logic exp_perr;

  always #5 clk = ~clk;

  user_mgr_arbiter dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
    .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .mgr_req_o(mgr_req_o), .mgr_addr_o(mgr_addr_o),
    .mgr_we_o(mgr_we_o), .mgr_be_o(mgr_be_o), .mgr_wdata_o(mgr_wdata_o),
    .mgr_gnt_i(mgr_gnt_i), .mgr_rvalid_i(mgr_rvalid_i), .mgr_rdata_i(mgr_rdata_i),
    .mgr_err_i(mgr_err_i), .proto_err_o(proto_err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef USER_MGR_ARB_PROTO_CHECK_EN
    exp_perr = 1'b1;
`else
    exp_perr = 1'b0;
`endif
    rst_i = 1'b1; req_i = 2'b11; we_i = 2'b00; be_i = 8'hFF;
    addr_i = {32'hA000_0001, 32'hA000_0000}; wdata_i = 64'h0;
    mgr_gnt_i = 1'b1; mgr_rvalid_i = 1'b0; mgr_rdata_i = 32'h0; mgr_err_i = 1'b0;
    #2;
    chk("rst_mgr_req", mgr_req_o, 0);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_err", err_o, 0);
    tick(); tick();
    chk("rst_perr", proto_err_o, 0);
    rst_i = 1'b0; req_i = 2'b00; mgr_gnt_i = 1'b0;
    tick();

    // Single port read, granted a cycle late, response two cycles after grant
    req_i = 2'b01; addr_i[31:0] = 32'h2000_0010;
    #1;
    chk("sp_req", mgr_req_o, 1);
    chk("sp_addr", mgr_addr_o, 32'h2000_0010);
    chk("sp_gnt_wait", gnt_o, 0);
    tick(); mgr_gnt_i = 1'b1; #1;
    chk("sp_gnt", gnt_o, 2'b01);
    tick(); req_i = 2'b00; mgr_gnt_i = 1'b0; #1;
    chk("sp_idle_req", mgr_req_o, 0);
    chk("sp_idle_addr", mgr_addr_o, 0);
    tick(); mgr_rvalid_i = 1'b1; mgr_rdata_i = 32'hCAFE_0001; #1;
    chk("sp_rvalid", rvalid_o, 2'b01);
    chk("sp_rdata", rdata_o, 32'hCAFE_0001);
    chk("sp_err", err_o, 0);
    tick(); mgr_rvalid_i = 1'b0; #1;
    chk("sp_rdata_zero", rdata_o, 0);

    // Contention: prio is now 1, so grants go 1,0,1; responses follow a cycle later
    addr_i = {32'hB000_0001, 32'hB000_0000};
    tick(); req_i = 2'b11; mgr_gnt_i = 1'b1; #1;
    chk("ct_gnt_a", gnt_o, 2'b10);
    chk("ct_addr_a", mgr_addr_o, 32'hB000_0001);
    tick(); mgr_rvalid_i = 1'b1; mgr_rdata_i = 32'hD000_0001; #1;
    chk("ct_gnt_b", gnt_o, 2'b01);
    chk("ct_rsp_b", rvalid_o, 2'b10);
    tick(); mgr_rdata_i = 32'hD000_0002; #1;
    chk("ct_gnt_c", gnt_o, 2'b10);
    chk("ct_rsp_c", rvalid_o, 2'b01);
    chk("ct_rdata_c", rdata_o, 32'hD000_0002);
    tick(); req_i = 2'b00; mgr_gnt_i = 1'b0; mgr_rdata_i = 32'hD000_0003; #1;
    chk("ct_rsp_d", rvalid_o, 2'b10);
    tick(); mgr_rvalid_i = 1'b0;

    // Lock: prio is 0; port 1 is offered first and must stay selected
    req_i = 2'b10; #1;
    chk("lk_addr1", mgr_addr_o, 32'hB000_0001);
    tick(); req_i = 2'b11; #1;
    chk("lk_hold1", mgr_addr_o, 32'hB000_0001);
    chk("lk_nognt", gnt_o, 0);
    tick(); #1;
    chk("lk_hold2", mgr_addr_o, 32'hB000_0001);
    tick(); mgr_gnt_i = 1'b1; #1;
    chk("lk_gnt", gnt_o, 2'b10);
    tick(); req_i = 2'b01; #1;
    chk("lk_gnt0", gnt_o, 2'b01);

    // Full stall: two outstanding (port1, port0)
    tick(); req_i = 2'b11; #1;
    chk("fs_req_low", mgr_req_o, 0);
    chk("fs_gnt_low", gnt_o, 0);
    tick(); mgr_rvalid_i = 1'b1; mgr_rdata_i = 32'hE000_0001; #1;
    chk("fs_req_pop", mgr_req_o, 0);
    chk("fs_rsp", rvalid_o, 2'b10);
    tick(); mgr_rvalid_i = 1'b0; #1;
    chk("fs_req_rise", mgr_req_o, 1);
    chk("fs_gnt", gnt_o, 2'b10);

    // Reset with two outstanding
    tick(); rst_i = 1'b1; req_i = 2'b00; mgr_gnt_i = 1'b0; #1;
    chk("rm_req", mgr_req_o, 0);
    tick(); rst_i = 1'b0; req_i = 2'b11; mgr_gnt_i = 1'b1; #1;
    chk("rm_gnt0", gnt_o, 2'b01);
    tick(); req_i = 2'b00; mgr_gnt_i = 1'b0; mgr_rvalid_i = 1'b1; mgr_rdata_i = 32'h1234_5678; #1;
    chk("rm_rsp", rvalid_o, 2'b01);
    chk("rm_perr", proto_err_o, 0);

    // Orphan response with empty FIFO
    tick(); mgr_rdata_i = 32'hDEAD_BEEF; #1;
    chk("or_rvalid", rvalid_o, 0);
    tick(); mgr_rvalid_i = 1'b0; #1;
    chk("or_perr", proto_err_o, exp_perr);
    chk("or_req", mgr_req_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/user_mgr_arbiter.md
# user_mgr_arbiter

Round-robin arbiter that shares the single user-domain OBI manager port between `NumReq` user-domain requesters (e.g. DMA, accelerator, debug streamer). It sits in front of the user manager output that is today tied to zero, drives it as one OBI manager, and tracks up to `MaxTrans` outstanding transactions so each response is returned to the requester that issued it. Responses are in order; no reordering or ID remapping is done.

## Interface
- `NumReq`, default 2: number of requester ports (2..8).
- `AddrWidth`, default 32: OBI address width.
- `DataWidth`, default 32: OBI data width; byte enable width is `DataWidth/8`.
- `MaxTrans`, default 2: maximum outstanding granted-but-unanswered transactions (1..8).

- `clk_i` in 1: single clock; all state on rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `req_i` in NumReq: per-port OBI request.
- `addr_i` in NumReq*AddrWidth: per-port address, port k at slice k.
- `we_i` in NumReq: per-port write enable.
- `be_i` in NumReq*DataWidth/8: per-port byte enables.
- `wdata_i` in NumReq*DataWidth: per-port write data.
- `gnt_o` out NumReq: per-port grant, one-hot or zero.
- `rvalid_o` out NumReq: per-port response valid, one-hot or zero.
- `rdata_o` out DataWidth: response data, shared by all ports.
- `err_o` out 1: response error, shared, valid with any `rvalid_o` bit.
- `mgr_req_o`, `mgr_addr_o`, `mgr_we_o`, `mgr_be_o`, `mgr_wdata_o` out 1/AddrWidth/1/DataWidth/8/DataWidth: manager-side request channel.
- `mgr_gnt_i` in 1: manager-side grant.
- `mgr_rvalid_i`, `mgr_rdata_i`, `mgr_err_i` in 1/DataWidth/1: manager-side response channel.
- `proto_err_o` out 1: sticky protocol-error flag (see Configuration).

## Operation
- State: round-robin pointer `prio` (idx), lock flag + locked index `sel_q`, ID FIFO of depth `MaxTrans` holding port indices, occupancy counter `cnt`.
- Selection, when unlocked: first port with `req_i` set, searching from `prio` upward with wrap-around. When locked: `sel_q`.
- `mgr_req_o` = (locked or any `req_i`) and `cnt < MaxTrans`. Addr/we/be/wdata muxed from selected port; zero when `mgr_req_o` low.
- Lock: if `mgr_req_o` high and `mgr_gnt_i` low, lock to current selection; held until grant. Requester must keep `req_i` high until granted (OBI rule); arbiter never switches away mid-request.
- Grant handshake (`mgr_req_o && mgr_gnt_i`): `gnt_o[sel]`=1 same cycle, push `sel` into FIFO, clear lock, `prio` = sel+1 mod NumReq.
- Response (`mgr_rvalid_i`): pop FIFO head h, `rvalid_o[h]`=1, `rdata_o`/`err_o` pass through same cycle.
- Simultaneous grant and response in one cycle: push and pop both happen, `cnt` unchanged.
- Full: `cnt == MaxTrans` forces `mgr_req_o` low, even if a response pops in the same cycle (decision uses registered `cnt`). Lock state is kept across the stall.
- Response with FIFO empty: dropped, no `rvalid_o`, protocol error raised.
- Reset mid-operation: FIFO, lock, `prio`, `cnt` cleared; outstanding transactions forgotten; later orphan responses treated as empty-FIFO responses.

## Timing
- Reset values: `prio`=0, unlocked, `cnt`=0, `proto_err_o`=0; hence `mgr_req_o`=0, `gnt_o`=0, `rvalid_o`=0, `rdata_o`=0, `err_o`=0 while `rst_i` is high.
- Request path combinational: `req_i` to `mgr_req_o` 0 cycles; `mgr_gnt_i` to `gnt_o` 0 cycles.
- Response path combinational: `mgr_rvalid_i` to `rvalid_o` 0 cycles; `rdata_o`/`err_o` are zero when `mgr_rvalid_i` is low.
- A granted transaction's response may arrive earliest the cycle after grant; back-to-back grants to alternating ports are possible every cycle while `cnt < MaxTrans`.

## Configuration
- `USER_MGR_ARB_PROTO_CHECK_EN` defined: `proto_err_o` sets (sticky until reset) on response with empty FIFO, or on `req_i[sel_q]` dropping while locked.
- Undefined: checker logic is omitted and `proto_err_o` is tied 0; orphan responses are still dropped.

## Test plan
- Single port: port 0 reads 0x2000_0010, gnt next cycle, rvalid two cycles later with 0xCAFE0001 -> `gnt_o`=01, then `rvalid_o`=01, `rdata_o`=0xCAFE0001.
- Contention: ports 0 and 1 request continuously, `mgr_gnt_i`=1 always, MaxTrans=2, responses 1 cycle after grant -> grants alternate 0,1,0,1; responses route in same order.
- Lock: port 1 requests, `mgr_gnt_i` low 3 cycles while port 0 also asserts -> address stays port 1's, first grant goes to port 1.
- Full stall: MaxTrans=2, two grants, no response -> `mgr_req_o` low; on first `mgr_rvalid_i` `mgr_req_o` stays low that cycle, rises next cycle.
- Orphan response: `mgr_rvalid_i`=1 with empty FIFO -> no `rvalid_o`; `proto_err_o`=1 when macro defined, 0 otherwise.
- Reset mid-op: `rst_i` pulsed with 2 outstanding -> after reset `cnt`=0, `prio`=0, next port 1 and 0 contention grants port 0 first.
